// File: rtl/uart_pkg.sv
// Shared state encoding, parity_mode encodings and parameter limits for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned DATA_BITS_MIN = 5;
    localparam int unsigned DATA_BITS_MAX = 9;
    localparam int unsigned STOP_BITS_MIN = 1;
    localparam int unsigned STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit for a latched UART word; par_en is low for the two "none" encodings.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic [DATA_BITS-1:0] data,
    input  logic [1:0]           mode,
    output logic                 par_en,
    output logic                 par_bit
);

    assign par_en  = (mode == PAR_EVEN) || (mode == PAR_ODD);
    assign par_bit = (^data) ^ (mode == PAR_ODD);

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to honour parity_mode; without it frames never carry a parity bit.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_mode,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned CntW = $clog2(DATA_BITS + 1);

    if ((DATA_BITS < DATA_BITS_MIN) || (DATA_BITS > DATA_BITS_MAX)) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS out of range");
    end
    if ((STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX)) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS out of range");
    end

    uart_state_e          state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

`ifdef UART_TX_PARITY_EN
    // Unshifted copy of the word so parity is computed from the whole frame payload.
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [1:0]           mode_q, mode_d;
    logic                 par_en, par_bit;

    uart_parity_calc #(
        .DATA_BITS(DATA_BITS)
    ) u_parity (
        .data   (data_q),
        .mode   (mode_q),
        .par_en (par_en),
        .par_bit(par_bit)
    );
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
        data_d     = data_q;
        mode_d     = mode_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    state_d = StLoad;
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    data_d  = tx_data;
                    mode_d  = parity_mode;
`endif
                end
            end
            StLoad: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = CntW'(1);
                    state_d   = StData;
                end
            end
            StData: begin
                if (baud_tick) begin
                    if (bit_cnt_q == CntW'(DATA_BITS)) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        if (par_en) begin
                            tx_d    = par_bit;
                            state_d = StParity;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = StStop;
                        end
`else
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = StStop;
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = StStop;
                end
            end
`endif
            StStop: begin
                if (baud_tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
            data_q     <= '0;
            mode_q     <= PAR_NONE;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
            data_q     <= data_d;
            mode_q     <= mode_d;
`endif
        end
    end

    assign tx_ready = (state_q == StIdle);
    assign tx_busy  = ~tx_ready;
    assign tx       = tx_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: an 8N1 and a 5-bit/2-stop instance share clk and baud_tick.
module tb_uart_tx_param;

    typedef struct {
        int          inst;
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic       clk;
    logic       baud_tick;
    bit         tick_en;
    int         tick_cnt;
    logic       rst_n_w  [2];
    logic       valid_w  [2];
    logic [8:0] data_w   [2];
    logic [1:0] mode_w   [2];
    logic       ready_w  [2];
    logic       tx_w     [2];
    logic       busy_w   [2];
    logic       done_w   [2];

    frame_t      exp_q[$];
    bit          in_frame [2];
    int          nbits    [2];
    logic [15:0] cur      [2];
    bit          pend_tick;

    int n_checks;
    int n_fail;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int unsigned Db = (k == 0) ? 8 : 5;
        localparam int unsigned Sb = (k == 0) ? 1 : 2;
        uart_tx_param #(
            .DATA_BITS(Db),
            .STOP_BITS(Sb)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n_w[k]),
            .baud_tick  (baud_tick),
            .tx_valid   (valid_w[k]),
            .tx_data    (data_w[k][Db-1:0]),
            .parity_mode(mode_w[k]),
            .tx_ready   (ready_w[k]),
            .tx         (tx_w[k]),
            .tx_busy    (busy_w[k]),
            .tx_done    (done_w[k])
        );
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference frame: the tx level held during each baud interval from START onward.
    function automatic frame_t make_frame(input int k, input logic [8:0] d, input logic [1:0] m);
        frame_t f;
        int     db, sb, n;
        logic   par;
        db     = (k == 0) ? 8 : 5;
        sb     = (k == 0) ? 1 : 2;
        f.inst = k;
        f.bits = '0;
        n      = 0;
        par    = 1'b0;
        f.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < db; i++) begin
            f.bits[n] = d[i];
            par ^= d[i];
            n++;
        end
`ifdef UART_TX_PARITY_EN
        if (m == 2'b01) begin
            f.bits[n] = par;
            n++;
        end else if (m == 2'b10) begin
            f.bits[n] = ~par;
            n++;
        end
`else
        if (m == 2'b11) par = 1'b0;
`endif
        for (int i = 0; i < sb; i++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len = n;
        return f;
    endfunction

    function automatic frame_t lit(input int k, input logic [15:0] bits, input int len);
        frame_t f;
        f.inst = k;
        f.bits = bits;
        f.len  = len;
        return f;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_tick = 1'b0;
        tick_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt++;
            baud_tick = tick_en && (tick_cnt % 4 == 0);
        end
    end

    // Monitor: pend_tick holds the baud_tick level the last rising edge saw.
    always @(negedge clk) begin : mon
        frame_t      f;
        logic [15:0] mask;
        bit          te;
        te = pend_tick;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n_w[k]) begin
                if (in_frame[k]) begin
                    in_frame[k] = 1'b0;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end else if (done_w[k]) begin
                chk("done_on_tick", 32'(te), 32'd1);
                chk("done_in_frame", 32'(in_frame[k]), 32'd1);
                if (in_frame[k]) begin
                    in_frame[k] = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("exp_available", 32'(exp_q.size()), 32'd1);
                    end else begin
                        f    = exp_q.pop_front();
                        mask = 16'((32'd1 << f.len) - 1);
                        chk("frame_inst", 32'(k), 32'(f.inst));
                        chk("frame_len", 32'(nbits[k]), 32'(f.len));
                        chk("frame_bits", 32'(cur[k] & mask), 32'(f.bits & mask));
                        chk("done_tx_high", 32'(tx_w[k]), 32'd1);
                        chk("done_ready", 32'(ready_w[k]), 32'd1);
                        chk("done_busy", 32'(busy_w[k]), 32'd0);
                    end
                end
            end else if (te) begin
                if (in_frame[k]) begin
                    if (nbits[k] < 16) cur[k][nbits[k]] = tx_w[k];
                    nbits[k]++;
                end else if (tx_w[k] == 1'b0) begin
                    in_frame[k] = 1'b1;
                    cur[k]      = '0;
                    nbits[k]    = 1;
                end
            end
        end
        pend_tick = baud_tick;
    end

    task automatic send_exp(input int k, input logic [8:0] d, input logic [1:0] m,
                            input frame_t f, input bit hold);
        bit acc;
        int n;
        exp_q.push_back(f);
        valid_w[k] = 1'b1;
        data_w[k]  = d;
        mode_w[k]  = m;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = ready_w[k];
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_in_time", 32'(acc), 32'd1);
        if (!hold) valid_w[k] = 1'b0;
        // Post-accept changes must not reach the frame in flight.
        data_w[k] = 9'($urandom);
        mode_w[k] = 2'($urandom);
    endtask

    task automatic send(input int k, input logic [8:0] d, input logic [1:0] m);
        send_exp(k, d, m, make_frame(k, d, m), 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("frame_complete_in_time", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   n;
        int   k;
        logic t0;
        int   n0;
        n_checks = 0;
        n_fail   = 0;
        tick_en  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rst_n_w[i]  = 1'b0;
            valid_w[i]  = 1'b0;
            data_w[i]   = '0;
            mode_w[i]   = 2'b00;
            in_frame[i] = 1'b0;
            nbits[i]    = 0;
            cur[i]      = '0;
        end
        pend_tick = 1'b0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx", 32'(tx_w[i]), 32'd1);
            chk("rst_busy", 32'(busy_w[i]), 32'd0);
            chk("rst_done", 32'(done_w[i]), 32'd0);
            chk("rst_ready", 32'(ready_w[i]), 32'd1);
        end
        @(posedge clk);
        #1;
        rst_n_w[0] = 1'b1;
        rst_n_w[1] = 1'b1;

        // Known-answer frames.
        send_exp(0, 9'h0A5, 2'b00, lit(0, 16'h034A, 10), 1'b0);
        wait_idle();
`ifdef UART_TX_PARITY_EN
        send_exp(0, 9'h007, 2'b01, lit(0, 16'h060E, 11), 1'b0);
        wait_idle();
        send_exp(0, 9'h007, 2'b10, lit(0, 16'h040E, 11), 1'b0);
        wait_idle();
`else
        send_exp(0, 9'h0A5, 2'b01, lit(0, 16'h034A, 10), 1'b0);
        wait_idle();
`endif
        send_exp(1, 9'h013, 2'b00, lit(1, 16'h00E6, 8), 1'b0);
        wait_idle();

        // Back-to-back: 0x55 held on tx_valid throughout the 0xA5 frame.
        send_exp(0, 9'h0A5, 2'b00, lit(0, 16'h034A, 10), 1'b1);
        data_w[0] = 9'h055;
        mode_w[0] = 2'b00;
        exp_q.push_back(make_frame(0, 9'h055, 2'b00));
        n = 0;
        while (exp_q.size() != 1 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("b2b_ready_rise", 32'(ready_w[0]), 32'd1);
        @(posedge clk);
        #1;
        chk("b2b_accept_first_edge", 32'(ready_w[0]), 32'd0);
        valid_w[0] = 1'b0;
        wait_idle();

        // Asynchronous reset during data bit 3 of 0xA5 (bit value 0).
        send_exp(0, 9'h0A5, 2'b00, make_frame(0, 9'h0A5, 2'b00), 1'b0);
        n = 0;
        while (!(in_frame[0] && nbits[0] == 5) && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_tx_before", 32'(tx_w[0]), 32'd0);
        rst_n_w[0] = 1'b0;
        #1;
        chk("abort_tx_async", 32'(tx_w[0]), 32'd1);
        chk("abort_ready", 32'(ready_w[0]), 32'd1);
        chk("abort_busy", 32'(busy_w[0]), 32'd0);
        chk("abort_done", 32'(done_w[0]), 32'd0);
        @(negedge clk);
        #1;
        chk("abort_dropped", 32'(exp_q.size()), 32'd0);
        valid_w[0] = 1'b1;
        data_w[0]  = 9'h03C;
        mode_w[0]  = 2'b00;
        exp_q.push_back(make_frame(0, 9'h03C, 2'b00));
        @(posedge clk);
        #1;
        rst_n_w[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge_accept", 32'(ready_w[0]), 32'd0);
        valid_w[0] = 1'b0;
        wait_idle();

        // Random frames; one of them stalls baud_tick mid-frame.
        for (int i = 0; i < 24; i++) begin
            k = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            send(k, 9'($urandom), 2'($urandom));
            if (i == 5) begin
                n = 0;
                while (!(in_frame[k] && nbits[k] == 3) && n < 1000) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                tick_en = 1'b0;
                repeat (2) @(negedge clk);
                #1;
                t0 = tx_w[k];
                n0 = nbits[k];
                repeat (40) @(negedge clk);
                #1;
                chk("stall_tx_hold", 32'(tx_w[k]), 32'(t0));
                chk("stall_busy", 32'(busy_w[k]), 32'd1);
                chk("stall_bits_hold", 32'(nbits[k]), 32'(n0));
                tick_en = 1'b1;
            end
            wait_idle();
        end

        repeat (20) @(negedge clk);
        chk("final_ready0", 32'(ready_w[0]), 32'd1);
        chk("final_ready1", 32'(ready_w[1]), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, sets data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, sets stop bits per frame; legal values 1 or 2.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 baud_tick  input  1  one-clk-wide bit-rate strobe from baud_gen.
REQ-006 tx_valid  input  1  data word offered.
REQ-007 tx_data  input  DATA_BITS  word to send, LSB first.
REQ-008 parity_mode  input  2  00 none, 01 even, 10 odd, 11 none; always present.
REQ-009 tx_ready  output  1  high only in IDLE; word accepted when tx_valid and tx_ready are both high on a clk edge.
REQ-010 tx  output  1  registered serial line; idle high.
REQ-011 tx_busy  output  1  high in every state except IDLE.
REQ-012 tx_done  output  1  one-clk pulse at frame end.

Function
REQ-013 The states SHALL be IDLE, LOAD, START, DATA, PARITY and STOP, encoded in a shared enum.
REQ-014 On accept, on any clk edge regardless of baud_tick, the block SHALL latch tx_data and parity_mode, enter LOAD and drop tx_ready on the next cycle.
REQ-015 From LOAD, at the next baud_tick the block SHALL set tx to 0 and enter START.
REQ-016 At each subsequent baud_tick tx SHALL take the next bit value: data bits 0..DATA_BITS-1, then the parity bit if enabled, then STOP_BITS stop bits of value 1.
REQ-017 Each bit SHALL last exactly one baud_tick interval; frame length is 1+DATA_BITS+P+STOP_BITS ticks, where P=1 when parity is active and 0 otherwise.
REQ-018 The even parity bit SHALL be the XOR of the data bits; the odd parity bit SHALL be its inverse; parity_mode 00 or 11 SHALL skip the PARITY state.
REQ-019 At the baud_tick that ends the last stop bit, the block SHALL enter IDLE, pulse tx_done high for exactly one clk and raise tx_ready on the same edge; tx SHALL remain 1.
REQ-020 tx_valid, tx_data and parity_mode SHALL be ignored while tx_ready is low; changes after accept SHALL not affect the frame in flight.
REQ-021 Without baud_tick, state, tx and the counters SHALL hold indefinitely.
REQ-022 The bit counter SHALL be sized ceil(log2(DATA_BITS+1)) and SHALL wrap to 0 on leaving DATA; the stop counter SHALL reset to 0 on entering STOP.
REQ-023 Back-to-back: a word presented in the cycle tx_ready rises SHALL be accepted, with no extra idle tick beyond LOAD.

Reset
REQ-024 While rst_n is low the block SHALL be in IDLE with tx=1, tx_busy=0, tx_done=0, tx_ready=1, and counters and shift register at 0.
REQ-025 Reset asserted mid-frame SHALL drive tx to 1 immediately (asynchronously) and abort the frame with no tx_done.
REQ-026 After reset release the first possible accept SHALL be on the first clk edge.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, parity_mode is honoured per REQ-018.
REQ-028 When UART_TX_PARITY_EN is undefined, parity_mode SHALL be ignored, the PARITY state and parity logic SHALL be absent, and P=0 always.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum, the parity_mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD) and the DATA_BITS/STOP_BITS legal limits.
REQ-030 A sub-module uart_parity_calc SHALL compute the parity bit from the latched word and mode; it is instantiated only under UART_TX_PARITY_EN.
REQ-031 Elaboration SHALL fail for illegal DATA_BITS or STOP_BITS values.

Verification
REQ-032 DATA_BITS=8, STOP_BITS=1, mode 00, send 0xA5 -> tx per tick 0,1,0,1,0,0,1,0,1,1; tx_done 10 ticks after START.
REQ-033 Macro defined, mode 01, send 0x07 -> parity bit 1, 11-tick frame; mode 10, send 0x07 -> parity bit 0.
REQ-034 DATA_BITS=5, STOP_BITS=2, send 0x13 -> 0,1,1,0,0,1,1,1; tx_done after 8 ticks.
REQ-035 tx_valid held with 0x55 during the frame for 0xA5 -> 0xA5 sent intact, then 0x55 accepted on the edge tx_ready rises.
REQ-036 rst_n pulsed low during DATA bit 3 -> tx=1 asynchronously, no tx_done, tx_ready=1 after release.
REQ-037 Macro undefined, mode 01, send 0xA5 -> 10-tick frame identical to REQ-032.
